// File: rtl/linear_result_collector_96_pkg.sv
// Shared types and sizing for the linear result collector.
// Holds word/vector types, buffer geometry and the output ReLU helper.
package linear_result_collector_96_pkg;

  localparam int DATA_W      = 32;
  localparam int VEC_LEN     = 32;
  localparam int N_GATES     = 3;
  localparam int TOTAL_WORDS = VEC_LEN * N_GATES;
  localparam int ADDR_W      = $clog2(TOTAL_WORDS);
  localparam int GATE_W      = $clog2(N_GATES);

  typedef logic signed [DATA_W-1:0] data_t;
  typedef data_t [VEC_LEN-1:0]      vec_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } collector_state_e;

  // Negative words clamp to zero when enabled; everything else passes through.
  function automatic data_t relu(input data_t x, input logic en);
    return (en && x[DATA_W-1]) ? '0 : x;
  endfunction

endpackage

// File: rtl/linear_result_collector_96_if.sv
// Input stream and output vector bus between the linear engine,
// the collector and the gate-activation stage.
interface linear_result_collector_96_if;
  import linear_result_collector_96_pkg::*;

  logic              clear;
  logic              relu_en;
  logic              in_valid;
  data_t             in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [GATE_W-1:0] out_gate;
  data_t             out_vector [VEC_LEN-1:0];
  logic              pass_done;

  // Environment side: producer of words and consumer of vectors.
  modport master (
    output clear, relu_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_gate, out_vector, pass_done
  );

  // Collector side.
  modport slave (
    input  clear, relu_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_gate, out_vector, pass_done
  );

endinterface

// File: rtl/linear_result_collector_96_buffer.sv
// 96-word result store: one write port, and a combinational read of the
// 32-word slice belonging to the selected gate.
module result_buffer_96
  import linear_result_collector_96_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  data_t             wdata,
  input  logic [GATE_W-1:0] rgate,
  output vec_t              rdata
);

  data_t mem [TOTAL_WORDS];

  // Word write; no reset because a pass always rewrites every word before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      assign rd_addr   = ADDR_W'(rgate) * ADDR_W'(VEC_LEN) + ADDR_W'(gi);
      assign rdata[gi] = mem[rd_addr];
    end
  endgenerate

endmodule

// File: rtl/linear_result_collector_96.sv
// Collects 96 serial results of one linear pass, then presents them as
// three 32-element gate vectors with optional ReLU. Single bank: input is
// blocked while the vectors drain.
module linear_result_collector_96
  import linear_result_collector_96_pkg::*;
(
  input logic                         clk,
  input logic                         rst,
  linear_result_collector_96_if.slave bus
);

  localparam logic [0:0]        ST_FILL   = FILL;
  localparam logic [0:0]        ST_DRAIN  = DRAIN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - 1);
  localparam logic [GATE_W-1:0] LAST_GATE = GATE_W'(N_GATES - 1);

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] wr_cnt_reg;
  logic [GATE_W-1:0] gate_cnt_reg;
  logic [GATE_W-1:0] out_gate_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  vec_t              out_vector_reg;
  vec_t              slice_raw;
  vec_t              slice_relu;
  logic              in_hs;
  logic              out_hs;
  logic              buf_we;

  assign in_hs  = bus.in_valid & in_ready_reg & (state_reg == ST_FILL);
  assign out_hs = out_valid_reg & bus.out_ready;
  // A word arriving together with clear is dropped.
  assign buf_we = in_hs & ~bus.clear;

  result_buffer_96 u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_cnt_reg),
    .wdata (bus.in_data),
    .rgate (gate_cnt_reg),
    .rdata (slice_raw)
  );

  generate
    for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_lane
      assign slice_relu[gi]     = relu(slice_raw[gi], bus.relu_en);
      assign bus.out_vector[gi] = out_vector_reg[gi];
    end
  endgenerate

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_gate  = out_gate_reg;
  // Pulses during the cycle the last gate is accepted, so the next pass can
  // start one cycle later; clear suppresses it.
  assign bus.pass_done = out_hs & (gate_cnt_reg == LAST_GATE) & ~bus.clear;

  // FSM, counters and the registered output vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_FILL;
      wr_cnt_reg     <= '0;
      gate_cnt_reg   <= '0;
      out_gate_reg   <= '0;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_vector_reg <= '0;
    end else if (bus.clear) begin
      state_reg     <= ST_FILL;
      wr_cnt_reg    <= '0;
      gate_cnt_reg  <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else if (state_reg == ST_FILL) begin
      in_ready_reg <= 1'b1;
      if (in_hs) begin
        if (wr_cnt_reg == LAST_ADDR) begin
          // Gate 0 slice is already complete, so it can be presented next cycle.
          state_reg      <= ST_DRAIN;
          wr_cnt_reg     <= '0;
          gate_cnt_reg   <= '0;
          in_ready_reg   <= 1'b0;
          out_valid_reg  <= 1'b1;
          out_gate_reg   <= gate_cnt_reg;
          out_vector_reg <= slice_relu;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + 1'b1;
        end
      end
    end else begin
      if (out_hs) begin
        out_valid_reg <= 1'b0;
        if (gate_cnt_reg == LAST_GATE) begin
          state_reg    <= ST_FILL;
          gate_cnt_reg <= '0;
          in_ready_reg <= 1'b1;
        end else begin
          gate_cnt_reg <= gate_cnt_reg + 1'b1;
        end
      end else if (!out_valid_reg) begin
        // Reload bubble: latch the next gate slice.
        out_valid_reg  <= 1'b1;
        out_gate_reg   <= gate_cnt_reg;
        out_vector_reg <= slice_relu;
      end
    end
  end

endmodule

// File: tb/tb_linear_result_collector_96.sv
// Self-checking bench for linear_result_collector_96: scoreboard of expected
// words, per-cycle handshake model, ReLU table and corner sequences.
module tb_linear_result_collector_96;
  import linear_result_collector_96_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  linear_result_collector_96_if bus();

  linear_result_collector_96 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] din;
    bit          relu;
    logic [31:0] exp;
  } vec_rec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Expected-behaviour model shared by the sequences
  logic [31:0] exp_q[$];
  bit          m_drain;
  int          m_gate;
  int          m_wr;
  bit          exp_ov;
  logic [31:0] last_g0e0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_drain = 0; m_gate = 0; m_wr = 0; exp_ov = 0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] word_val(input int mode, input logic [31:0] base, input int idx);
    case (mode)
      0:       return base + 32'(idx);
      1:       return (idx % 2 == 0) ? -32'(idx + 1) : 32'(idx);
      default: return base;
    endcase
  endfunction

  function automatic logic [31:0] ref_relu(input logic [31:0] v, input bit r);
    return (r && v[31]) ? 32'h0 : v;
  endfunction

  // Streams n_words words and consumes vectors until every pass completes.
  task automatic run_pass(input string tag, input int n_words, input int mode, input logic [31:0] base,
                          input bit relu, input int gap_pct, input int stall, input int clear_at,
                          input bit stop_g1);
    int          sent = 0, pd_seen = 0, passes, budget = 0, hold = 0, last_in_cyc = 0, bad;
    bit          cleared = 0, force_valid = 0, in_hs, out_hs, same;
    logic [31:0] cur_base, snap_gate;
    logic [31:0] snap [VEC_LEN];
    logic [31:0] ev   [VEC_LEN];
    passes      = n_words / TOTAL_WORDS;
    bus.relu_en = relu;
    while (pd_seen < passes) begin
      if (stop_g1 && m_drain && m_gate == 1 && exp_ov) return;
      if (budget++ > 4000) begin
        n_checks++;
        $display("FAIL %s timeout: got %0d passes, required %0d", tag, pd_seen, passes);
        break;
      end
      cur_base  = (clear_at > 0 && !cleared) ? base + 32'd5000 : base;
      bus.clear = 1'b0;
      if (clear_at > 0 && !cleared && sent == clear_at) begin
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
      end else if (sent < n_words && (force_valid || int'($urandom_range(99)) >= gap_pct)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = word_val(mode, cur_base, sent % TOTAL_WORDS);
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
      end
      bus.out_ready = !(bus.out_valid && hold < stall);
      #1;
      in_hs  = bus.in_valid && bus.in_ready;
      out_hs = bus.out_valid && bus.out_ready;
      chk({tag, " in_ready"},  32'(bus.in_ready),  32'(!m_drain));
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
      chk({tag, " pass_done"}, 32'(bus.pass_done), 32'(out_hs && m_gate == N_GATES - 1 && !bus.clear));
      if (force_valid) begin
        chk({tag, " b2b_accept"}, 32'(in_hs), 32'd1);
        force_valid = 0;
      end
      if (bus.out_valid && !bus.out_ready) begin
        if (hold == 0) begin
          snap_gate = 32'(bus.out_gate);
          for (int i = 0; i < VEC_LEN; i++) snap[i] = bus.out_vector[i];
        end else begin
          same = (32'(bus.out_gate) == snap_gate);
          for (int i = 0; i < VEC_LEN; i++) if (bus.out_vector[i] !== snap[i]) same = 0;
          chk({tag, " hold_stable"}, 32'(same), 32'd1);
        end
        hold++;
      end
      if (out_hs) begin
        hold = 0;
        chk({tag, " out_gate"}, 32'(bus.out_gate), 32'(m_gate));
        if (exp_q.size() < VEC_LEN) begin
          chk({tag, " sb_underflow"}, 32'(exp_q.size()), 32'(VEC_LEN));
        end else begin
          bad = -1;
          for (int i = 0; i < VEC_LEN; i++) begin
            ev[i] = exp_q.pop_front();
            if (bus.out_vector[i] !== ev[i] && bad < 0) bad = i;
          end
          if (bad < 0) bad = 0;
          chk($sformatf("%s vec g%0d e%0d", tag, m_gate, bad), bus.out_vector[bad], ev[bad]);
          if (m_gate == 0) last_g0e0 = bus.out_vector[0];
        end
      end
      // advance the model to the next cycle
      if (bus.clear) begin
        model_reset();
        cleared = 1; sent = 0;
      end else if (!m_drain) begin
        if (in_hs) begin
          exp_q.push_back(ref_relu(bus.in_data, relu));
          sent++; m_wr++;
          if (m_wr == TOTAL_WORDS) begin
            m_wr = 0; m_drain = 1; exp_ov = 1; last_in_cyc = cyc_n;
          end
        end
      end else if (out_hs) begin
        exp_ov = 0;
        if (m_gate == N_GATES - 1) begin
          m_gate = 0; m_drain = 0; pd_seen++;
          if (stall == 0) chk({tag, " drain_latency"}, 32'(cyc_n - last_in_cyc), 32'd5);
          force_valid = (sent < n_words);
        end else begin
          m_gate++;
        end
      end else if (!exp_ov) begin
        exp_ov = 1;
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    if (!stop_g1) chk({tag, " sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  vec_rec_t    tbl [8];
  logic [31:0] acc;

  initial begin
    tbl[0] = '{32'h8000_0000, 1'b1, 32'h0000_0000};
    tbl[1] = '{32'h8000_0000, 1'b0, 32'h8000_0000};
    tbl[2] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    tbl[3] = '{32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF};
    tbl[4] = '{32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[5] = '{32'h1234_5678, 1'b0, 32'h1234_5678};
    tbl[6] = '{32'hFFFF_FFF6, 1'b0, 32'hFFFF_FFF6};
    tbl[7] = '{32'h0000_0001, 1'b1, 32'h0000_0001};

    rst = 1'b1;
    bus.clear = 1'b0; bus.relu_en = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready",  32'(bus.in_ready),  32'd0);
    chk("reset pass_done", 32'(bus.pass_done), 32'd0);
    chk("reset out_gate",  32'(bus.out_gate),  32'd0);
    acc = '0;
    for (int i = 0; i < VEC_LEN; i++) acc = acc | bus.out_vector[i];
    chk("reset out_vector", acc, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("release in_ready first cycle", 32'(bus.in_ready), 32'd0);
    cyc();
    #1;
    chk("release in_ready second cycle", 32'(bus.in_ready), 32'd1);
    cyc();

    // index pattern, no ReLU, full-rate consumer
    run_pass("idx", 96, 0, 32'd0, 1'b0, 0, 0, 0, 1'b0);
    // alternating negative/positive with ReLU
    run_pass("relu", 96, 1, 32'd0, 1'b1, 0, 0, 0, 1'b0);

    // ReLU boundary table: one constant-filled pass per record
    for (int k = 0; k < 8; k++) begin
      run_pass($sformatf("tbl%0d", k), 96, 2, tbl[k].din, tbl[k].relu, 0, 0, 0, 1'b0);
      chk($sformatf("tbl%0d g0e0", k), last_g0e0, tbl[k].exp);
    end

    // backpressure on every gate, in_valid held high through DRAIN
    run_pass("stall", 192, 0, 32'd200, 1'b0, 0, 10, 0, 1'b0);
    // random input gaps over two back-to-back passes
    run_pass("gaps", 192, 0, 32'd7000, 1'b0, 50, 0, 0, 1'b0);

    // clear after 40 stale words, then a clean pass of 1000+index
    run_pass("clear", 96, 0, 32'd1000, 1'b0, 0, 0, 40, 1'b0);
    chk("clear g0e0", last_g0e0, 32'd1000);

    // asynchronous reset while gate 1 is presented
    run_pass("rstmid", 96, 0, 32'd300, 1'b0, 0, 0, 0, 1'b1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid in_ready",  32'(bus.in_ready),  32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_mid release in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    run_pass("after_rst", 96, 0, 32'd400, 1'b0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
